// File: rtl/captura_de_comandos.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// captura_de_comandos
//
// Front end for the board's 8 switches and 4 push-buttons. Every raw input is
// brought through a two-flop synchroniser; buttons are active-low on the board
// and are inverted after synchronisation so all internal words are
// active-high. Two independent channels (one per user) debounce a 6-bit
// command word and publish a stable, registered User/Func pair plus a
// one-cycle change strobe.
//
// Ports
//   CLK       system clock, all state changes on the rising edge
//   RST_N     synchronous, active-low reset
//   CH[7:0]   raw switches, active-high (CH[i] = switch CHi)
//   BTN[3:0]  raw buttons, active-low (BTN[i] = button BTNi, 0 = pressed)
//   User0     committed {CH0,CH1,CH2}
//   Func0     committed {CH3,~BTN0,~BTN1}
//   User1     committed {CH4,CH5,CH6}
//   Func1     committed {CH7,~BTN2,~BTN3}
//   Changed0  one-cycle pulse when {User0,Func0} is updated
//   Changed1  one-cycle pulse when {User1,Func1} is updated
//   Busy0     channel 0 is settling a candidate word
//   Busy1     channel 1 is settling a candidate word
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a commit (>= 1)
//   CNT_W            settle counter width, 2**CNT_W >= DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
module captura_de_comandos #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] CH,
  input  logic [3:0] BTN,
  output logic [2:0] User0,
  output logic [2:0] Func0,
  output logic [2:0] User1,
  output logic [2:0] Func1,
  output logic       Changed0,
  output logic       Changed1,
  output logic       Busy0,
  output logic       Busy1
);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  // Terminal count: the counter stops here and the commit happens instead.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]             ch_meta, ch_sync;
  logic [3:0]             btn_meta, btn_sync;

  logic [1:0][5:0]        word;
  logic [1:0][5:0]        committed;
  logic [1:0][5:0]        candidate;
  logic [1:0][CNT_W-1:0]  count;
  state_t                 state [2];
  logic [1:0]             changed;
  logic [1:0]             busy;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Buttons reset to 1 so a reset looks "released".
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ch_meta  <= '0;
      ch_sync  <= '0;
      btn_meta <= '1;
      btn_sync <= '1;
    end else begin
      ch_meta  <= CH;
      ch_sync  <= ch_meta;
      btn_meta <= BTN;
      btn_sync <= btn_meta;
    end
  end

  // Channel words, MSB first as listed on the outputs; buttons inverted here.
  assign word[0] = {ch_sync[0], ch_sync[1], ch_sync[2], ch_sync[3],
                    ~btn_sync[0], ~btn_sync[1]};
  assign word[1] = {ch_sync[4], ch_sync[5], ch_sync[6], ch_sync[7],
                    ~btn_sync[2], ~btn_sync[3]};

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSM. Busy and Changed are registered alongside the
  // state so no input reaches an output without passing through a flop.
  // ---------------------------------------------------------------------------
  // NOTE: every register here is a plain flop (no RAM), so all of them,
  // candidates and counters included, get an explicit reset value.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int c = 0; c < 2; c++) begin
        state[c]     <= STABLE;
        committed[c] <= '0;
        candidate[c] <= '0;
        count[c]     <= '0;
        changed[c]   <= 1'b0;
        busy[c]      <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        changed[c] <= 1'b0;
        case (state[c])
          STABLE: begin
            if (word[c] != committed[c]) begin
              candidate[c] <= word[c];
              count[c]     <= '0;
              state[c]     <= SETTLING;
              busy[c]      <= 1'b1;
            end
          end
          SETTLING: begin
            if (word[c] == committed[c]) begin
              // Input fell back to the committed word: abandon quietly.
              state[c] <= STABLE;
              busy[c]  <= 1'b0;
            end else if (word[c] != candidate[c]) begin
              // Bounce to a different word: restart the settle window.
              candidate[c] <= word[c];
              count[c]     <= '0;
            end else if (count[c] == LAST) begin
              committed[c] <= candidate[c];
              changed[c]   <= 1'b1;
              state[c]     <= STABLE;
              busy[c]      <= 1'b0;
            end else begin
              count[c] <= count[c] + 1'b1;
            end
          end
          default: begin
            state[c] <= STABLE;
            busy[c]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign User0    = committed[0][5:3];
  assign Func0    = committed[0][2:0];
  assign User1    = committed[1][5:3];
  assign Func1    = committed[1][2:0];
  assign Changed0 = changed[0];
  assign Changed1 = changed[1];
  assign Busy0    = busy[0];
  assign Busy1    = busy[1];

endmodule

// File: doc/captura_de_comandos.md
Name: captura_de_comandos

Overview:
- Input front end for the board's 8 switches and 4 push-buttons. The buttons are active-low on the board.
- Synchronises every input and debounces each user's command word.
- Publishes stable, registered User/Func codes for both users, plus a one-cycle change strobe per user.
- Its outputs feed the permission checker, priority comparator and functionality decoders in place of raw switch/button wiring.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a new word is committed (10 ms at 50 MHz). Legal range is ≥1.
- CNT_W, 20: width of the settle counter. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- CH  input  8  raw switches CH0..CH7; CH[i] is switch CHi; active-high.
- BTN  input  4  raw buttons BTN0..BTN3; BTN[i] is button BTNi; active-low (0 = pressed).
- User0  output  3  committed {CH0,CH1,CH2}.
- Func0  output  3  committed {CH3,~BTN0,~BTN1}.
- User1  output  3  committed {CH4,CH5,CH6}.
- Func1  output  3  committed {CH7,~BTN2,~BTN3}.
- Changed0  output  1  one-cycle pulse when {User0,Func0} is updated.
- Changed1  output  1  one-cycle pulse when {User1,Func1} is updated.
- Busy0  output  1  channel 0 is settling a candidate word.
- Busy1  output  1  channel 1 is settling a candidate word.

Behaviour:
- Reset: one clock, synchronous; RST_N low at an edge forces reset values.
  - All outputs reset to 0.
  - CH synchronisers reset to 0; BTN synchronisers reset to 1 (released).
  - FSMs go to STABLE, counters to 0, candidates to 0.
- Synchroniser: two-flop synchroniser on each of the 12 inputs. Buttons are inverted after synchronisation, so internal words are active-high.
- Channels: two independent channels.
  - Channel 0 word W0 = {sCH0,sCH1,sCH2,sCH3,~sBTN0,~sBTN1}.
  - Channel 1 word W1 = {sCH4,sCH5,sCH6,sCH7,~sBTN2,~sBTN3}.
  - Each channel holds: committed C (drives User/Func), candidate K, counter N, and state.
- FSM per channel, states STABLE and SETTLING.
  - STABLE, W == C: hold; Busy = 0.
  - STABLE, W != C: K <= W, N <= 0, go to SETTLING.
  - SETTLING, W == C: return to STABLE. No commit, no pulse, C unchanged.
  - SETTLING, W != C and W != K: K <= W, N <= 0, stay in SETTLING (bounce restart).
  - SETTLING, W == K and N == DEBOUNCE_CYCLES-1: C <= K, Changed <= 1 for exactly one cycle, go to STABLE.
  - SETTLING, W == K otherwise: N <= N+1.
- Busy is registered and equals (state == SETTLING).
- Latency: a raw change first sampled at edge k, then held, is committed at edge k+2+DEBOUNCE_CYCLES. Outputs are visible after that edge.
- DEBOUNCE_CYCLES = 1: commit occurs on the edge after SETTLING entry.
- Channels never interact. Simultaneous commits on both channels pulse Changed0 and Changed1 in the same cycle.
- Changed is never asserted on two consecutive cycles. A commit always follows a full settle window.
- Reset mid-SETTLING: the pending candidate is discarded and no pulse is produced. After release, inputs still held re-settle with the full latency.
- The counter never wraps: it is cleared on entry or restart and stops at DEBOUNCE_CYCLES-1.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset with DEBOUNCE_CYCLES=4, CH=8'h00, BTN=4'b1111, RST_N low 3 cycles then high 10 cycles -> all outputs 0 throughout. Busy0/1 and Changed0/1 never assert.
2. Same setup, CH0=CH2=1 from edge k and held -> Busy0=1 after edge k+2. User0=3'b101 and Changed0=1 for one cycle after edge k+6; Busy0=0 after edge k+6. Channel 1 outputs stay 0.
3. BTN0 low 2 cycles, high 1 cycle, then low steady from edge k -> single Changed0 pulse. Func0=3'b010 appears after edge k+6, not earlier.
4. CH7 high for 3 cycles then low -> Busy1 pulses then clears. Changed1 never asserts; Func1 stays 3'b000.
5. CH0..CH2 and CH4..CH6 all set to 1 on the same edge k -> User0=User1=3'b111 after edge k+6. Changed0 and Changed1 assert in the same cycle.
6. CH4=1 at edge k, RST_N low at edge k+4 for 1 cycle, CH4 held -> no Changed1 and User1=0 at reset. User1=3'b100 with Changed1 occurs 6 edges after RST_N returns high.
